// File: rtl/usr_sw_pkg.sv
// Shared constants for the user DIP-switch input conditioner.
package usr_sw_pkg;

    localparam int USR_SW_WIDTH         = 8;
    localparam int USR_SW_DEBOUNCE_10MS = 2000000;
    localparam int USR_SW_SYNC_STAGES   = 2;

endpackage : usr_sw_pkg

// File: rtl/usr_sw_debounce_bit.sv
// One switch bit: synchronizer, debounce counter, stable level and edge pulses.
// Next-cycle level/change are also exported so the parent can register events on the same edge.
module usr_sw_debounce_bit
    import usr_sw_pkg::*;
#(
    parameter int SYNC_STAGES     = USR_SW_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = USR_SW_DEBOUNCE_10MS,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_i,
    output logic state_o,
    output logic rise_o,
    output logic fall_o,
    output logic state_nxt_o,
    output logic chg_nxt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   stable_q;
    logic                   stable_d;
    logic                   rise_q;
    logic                   rise_d;
    logic                   fall_q;
    logic                   fall_d;
    logic                   sync_s;

    // Synchronizer shift and debounce next-state
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], sw_i};
        sync_s   = sync_q[SYNC_STAGES-1];
        cnt_d    = cnt_q;
        stable_d = stable_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        if (sync_s == stable_q) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (cnt_q == CNT_MAX) begin
            stable_d = sync_s;
            cnt_d    = {CNT_W{1'b0}};
            rise_d   = sync_s;
            fall_d   = ~sync_s;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= {SYNC_STAGES{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign state_o     = stable_q;
    assign rise_o      = rise_q;
    assign fall_o      = fall_q;
    assign state_nxt_o = stable_d;
    assign chg_nxt_o   = rise_d | fall_d;

endmodule : usr_sw_debounce_bit

// File: rtl/usr_sw_conditioner.sv
// DIP-switch conditioner: per-bit debounce plus a one-entry valid/ready change-event record
// with merge-on-backpressure and a sticky overflow flag.
module usr_sw_conditioner
    import usr_sw_pkg::*;
#(
    parameter int WIDTH           = USR_SW_WIDTH,
    parameter int SYNC_STAGES     = USR_SW_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = USR_SW_DEBOUNCE_10MS,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic             sys0_clk,
    input  logic             sys0_rstn,
    input  logic [WIDTH-1:0] usr_sw_i,
    output logic [WIDTH-1:0] sw_state,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [WIDTH-1:0] evt_state,
    output logic [WIDTH-1:0] evt_mask,
    output logic             evt_ovf,
    input  logic             ovf_clr
);

    logic [WIDTH-1:0] state_nxt_s;
    logic [WIDTH-1:0] chg_nxt_s;
    logic             evt_valid_q;
    logic             evt_valid_d;
    logic [WIDTH-1:0] evt_state_q;
    logic [WIDTH-1:0] evt_state_d;
    logic [WIDTH-1:0] evt_mask_q;
    logic [WIDTH-1:0] evt_mask_d;
    logic             evt_ovf_q;
    logic             evt_ovf_d;
    logic             ovf_set_s;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        usr_sw_debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_bit (
            .clk         (sys0_clk),
            .rst_n       (sys0_rstn),
            .sw_i        (usr_sw_i[i]),
            .state_o     (sw_state[i]),
            .rise_o      (sw_rise[i]),
            .fall_o      (sw_fall[i]),
            .state_nxt_o (state_nxt_s[i]),
            .chg_nxt_o   (chg_nxt_s[i])
        );
    end

    // Event record: driven from next-cycle changes so evt_valid rises with the pulse
    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_state_d = evt_state_q;
        evt_mask_d  = evt_mask_q;
        ovf_set_s   = 1'b0;
        if (chg_nxt_s != {WIDTH{1'b0}}) begin
            if (!evt_valid_q || evt_ready) begin
                evt_valid_d = 1'b1;
                evt_state_d = state_nxt_s;
                evt_mask_d  = chg_nxt_s;
            end else begin
                evt_state_d = state_nxt_s;
                evt_mask_d  = evt_mask_q | chg_nxt_s;
                ovf_set_s   = 1'b1;
            end
        end else if (evt_valid_q && evt_ready) begin
            evt_valid_d = 1'b0;
            evt_mask_d  = {WIDTH{1'b0}};
        end else begin
            evt_valid_d = evt_valid_q;
        end
        if (ovf_set_s) begin
            evt_ovf_d = 1'b1;
        end else if (ovf_clr) begin
            evt_ovf_d = 1'b0;
        end else begin
            evt_ovf_d = evt_ovf_q;
        end
    end

    // Event record registers
    always_ff @(posedge sys0_clk or negedge sys0_rstn) begin
        if (!sys0_rstn) begin
            evt_valid_q <= 1'b0;
            evt_state_q <= {WIDTH{1'b0}};
            evt_mask_q  <= {WIDTH{1'b0}};
            evt_ovf_q   <= 1'b0;
        end else begin
            evt_valid_q <= evt_valid_d;
            evt_state_q <= evt_state_d;
            evt_mask_q  <= evt_mask_d;
            evt_ovf_q   <= evt_ovf_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_state = evt_state_q;
    assign evt_mask  = evt_mask_q;
    assign evt_ovf   = evt_ovf_q;

endmodule : usr_sw_conditioner

// File: tb/tb_usr_sw_conditioner.sv
// Directed self-checking bench for usr_sw_conditioner with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
module tb_usr_sw_conditioner;

    logic       sys0_clk;
    logic       sys0_rstn;
    logic [7:0] usr_sw_i;
    logic [7:0] sw_state;
    logic [7:0] sw_rise;
    logic [7:0] sw_fall;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_state;
    logic [7:0] evt_mask;
    logic       evt_ovf;
    logic       ovf_clr;

    int vec_cnt;
    int err_cnt;

    usr_sw_conditioner #(
        .WIDTH           (8),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .sys0_clk  (sys0_clk),
        .sys0_rstn (sys0_rstn),
        .usr_sw_i  (usr_sw_i),
        .sw_state  (sw_state),
        .sw_rise   (sw_rise),
        .sw_fall   (sw_fall),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_state (evt_state),
        .evt_mask  (evt_mask),
        .evt_ovf   (evt_ovf),
        .ovf_clr   (ovf_clr)
    );

    initial sys0_clk = 1'b0;
    always #5 sys0_clk = ~sys0_clk;

    task automatic check_vec(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        vec_cnt++;
        if (obs !== exp_v) begin
            err_cnt++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge sys0_clk);
            #1;
        end
    endtask

    task automatic do_reset();
        sys0_rstn = 1'b0;
        tick(3);
        sys0_rstn = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check_vec({tag, "_state"}, sw_state, 8'h00);
        check_vec({tag, "_rise"},  sw_rise,  8'h00);
        check_vec({tag, "_fall"},  sw_fall,  8'h00);
        check_vec({tag, "_valid"}, 8'(evt_valid), 8'h00);
        check_vec({tag, "_estate"}, evt_state, 8'h00);
        check_vec({tag, "_emask"}, evt_mask, 8'h00);
        check_vec({tag, "_ovf"},   8'(evt_ovf), 8'h00);
    endtask

    logic [7:0] seen;

    initial begin
        vec_cnt   = 0;
        err_cnt   = 0;
        sys0_rstn = 1'b0;
        usr_sw_i  = 8'h00;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        tick(3);
        check_all_zero("rst");
        sys0_rstn = 1'b1;
        tick(2);

        // Scenario 1: single rise, accepted 6 edges after the change (sync 2 + debounce 4)
        usr_sw_i = 8'h01;
        tick(5);
        check_vec("s1_early_state", sw_state, 8'h00);
        check_vec("s1_early_valid", 8'(evt_valid), 8'h00);
        tick(1);
        check_vec("s1_state", sw_state, 8'h01);
        check_vec("s1_rise", sw_rise, 8'h01);
        check_vec("s1_valid", 8'(evt_valid), 8'h01);
        check_vec("s1_estate", evt_state, 8'h01);
        check_vec("s1_emask", evt_mask, 8'h01);
        tick(1);
        check_vec("s1_rise_end", sw_rise, 8'h00);
        evt_ready = 1'b1;
        tick(1);
        check_vec("s1_accept_valid", 8'(evt_valid), 8'h00);
        check_vec("s1_accept_mask", evt_mask, 8'h00);
        evt_ready = 1'b0;

        // Scenario 2: bit 3 glitch shorter than the debounce window
        seen = 8'h00;
        usr_sw_i = 8'h09;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            seen = seen | sw_rise | sw_fall;
        end
        usr_sw_i = 8'h01;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            seen = seen | sw_rise | sw_fall;
        end
        check_vec("s2_no_pulse", seen, 8'h00);
        check_vec("s2_state", sw_state, 8'h01);
        check_vec("s2_valid", 8'(evt_valid), 8'h00);

        // Scenario 3: merge under backpressure, then ovf_clr
        usr_sw_i = 8'h00;
        do_reset();
        tick(2);
        evt_ready = 1'b0;
        usr_sw_i = 8'h01;
        tick(6);
        check_vec("s3_first_valid", 8'(evt_valid), 8'h01);
        check_vec("s3_first_ovf", 8'(evt_ovf), 8'h00);
        tick(2);
        usr_sw_i = 8'h81;
        tick(6);
        check_vec("s3_valid", 8'(evt_valid), 8'h01);
        check_vec("s3_estate", evt_state, 8'h81);
        check_vec("s3_emask", evt_mask, 8'h81);
        check_vec("s3_ovf", 8'(evt_ovf), 8'h01);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check_vec("s3_ovf_clr", 8'(evt_ovf), 8'h00);
        check_vec("s3_estate_hold", evt_state, 8'h81);

        // Scenario 6: ovf_clr coincident with a merge, set wins
        usr_sw_i = 8'h80;
        tick(5);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check_vec("s6_fall", sw_fall, 8'h01);
        check_vec("s6_ovf", 8'(evt_ovf), 8'h01);
        check_vec("s6_estate", evt_state, 8'h80);
        check_vec("s6_emask", evt_mask, 8'h81);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check_vec("s6_ovf_clr", 8'(evt_ovf), 8'h00);
        evt_ready = 1'b1;
        tick(1);
        check_vec("s6_drain_valid", 8'(evt_valid), 8'h00);

        // Scenario 4: ready held high, two back-to-back records
        usr_sw_i = 8'h00;
        do_reset();
        tick(2);
        evt_ready = 1'b1;
        usr_sw_i = 8'h10;
        tick(6);
        check_vec("s4a_valid", 8'(evt_valid), 8'h01);
        check_vec("s4a_estate", evt_state, 8'h10);
        check_vec("s4a_emask", evt_mask, 8'h10);
        tick(1);
        check_vec("s4a_drop", 8'(evt_valid), 8'h00);
        usr_sw_i = 8'h00;
        tick(6);
        check_vec("s4b_fall", sw_fall, 8'h10);
        check_vec("s4b_valid", 8'(evt_valid), 8'h01);
        check_vec("s4b_estate", evt_state, 8'h00);
        check_vec("s4b_emask", evt_mask, 8'h10);
        tick(1);
        check_vec("s4b_drop", 8'(evt_valid), 8'h00);

        // Scenario 5: switches held high through reset, then reset mid-count
        evt_ready = 1'b0;
        usr_sw_i  = 8'hFF;
        sys0_rstn = 1'b0;
        tick(3);
        check_all_zero("s5_rst");
        sys0_rstn = 1'b1;
        tick(5);
        check_vec("s5_early", sw_state, 8'h00);
        tick(1);
        check_vec("s5_rise", sw_rise, 8'hFF);
        check_vec("s5_state", sw_state, 8'hFF);
        check_vec("s5_emask", evt_mask, 8'hFF);
        tick(1);
        check_vec("s5_rise_end", sw_rise, 8'h00);
        usr_sw_i = 8'h0F;
        tick(4);
        sys0_rstn = 1'b0;
        usr_sw_i  = 8'h00;
        tick(2);
        check_all_zero("s5_mid");
        sys0_rstn = 1'b1;
        seen = 8'h00;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            seen = seen | sw_rise | sw_fall;
        end
        check_vec("s5_post_pulse", seen, 8'h00);
        check_vec("s5_post_state", sw_state, 8'h00);
        check_vec("s5_post_valid", 8'(evt_valid), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule : tb_usr_sw_conditioner
